// File: rtl/writeback_unit.sv
// MEM/WB pipeline register, 16 x 16-bit register file with two combinational read ports,
// and a saturating commit counter. Optional MEM/WB-to-read bypass under `WB_BYPASS_EN.
module writeback_unit #(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic          clkwire,
  input  logic          resetn,
  input  logic          checkwritedata,
  input  logic [3:0]    regnum,
  input  logic [DW-1:0] writedata,
  input  logic          stall,
  input  logic [3:0]    readreg1,
  input  logic [3:0]    readreg2,
  output logic [DW-1:0] readdata1,
  output logic [DW-1:0] readdata2,
  output logic          wbvalid,
  output logic [3:0]    wbreg,
  output logic [DW-1:0] wbdata,
  output logic [15:0]   retired
);

  logic          r_wbvalid;
  logic [3:0]    r_wbreg;
  logic [DW-1:0] r_wbdata;
  logic [15:0]   r_retired;
  logic [DW-1:0] r_regs [NREGS];

  logic          w_commit;
  logic          w_byp1;
  logic          w_byp2;

  // Register 0 is never written, so it reads as zero from the array as well.
  assign w_commit = r_wbvalid & ~stall & (r_wbreg != 4'd0);

  // MEM/WB pipeline register: loads every unstalled edge, holds under stall.
  always_ff @(posedge clkwire or negedge resetn) begin
    if (!resetn) begin
      r_wbvalid <= 1'b0;
      r_wbreg   <= 4'd0;
      r_wbdata  <= {DW{1'b0}};
    end else if (!stall) begin
      r_wbvalid <= checkwritedata;
      r_wbreg   <= regnum;
      r_wbdata  <= writedata;
    end else begin
      r_wbvalid <= r_wbvalid;
      r_wbreg   <= r_wbreg;
      r_wbdata  <= r_wbdata;
    end
  end

  // Register file commit from the MEM/WB entry.
  always_ff @(posedge clkwire or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DW{1'b0}};
      end
    end else if (w_commit) begin
      r_regs[r_wbreg] <= r_wbdata;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Saturating count of committed writes.
  always_ff @(posedge clkwire or negedge resetn) begin
    if (!resetn) begin
      r_retired <= 16'd0;
    end else if (w_commit && (r_retired != 16'hFFFF)) begin
      r_retired <= r_retired + 16'd1;
    end else begin
      r_retired <= r_retired;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the pending entry even while stalled; it is the newest value of that register.
  assign w_byp1 = r_wbvalid & (r_wbreg == readreg1);
  assign w_byp2 = r_wbvalid & (r_wbreg == readreg2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign readdata1 = (readreg1 == 4'd0) ? {DW{1'b0}} :
                     w_byp1             ? r_wbdata    : r_regs[readreg1];
  assign readdata2 = (readreg2 == 4'd0) ? {DW{1'b0}} :
                     w_byp2             ? r_wbdata    : r_regs[readreg2];

  assign wbvalid = r_wbvalid;
  assign wbreg   = r_wbreg;
  assign wbdata  = r_wbdata;
  assign retired = r_retired;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final (WB) stage of the 5-stage pipeline: receives the memory stage's write-back triple (checkwritedata, regnum, writedata), registers it in the MEM/WB pipeline register and commits it to a 16 x 16-bit register file one cycle later. Provides two combinational read ports for the decode stage, with optional bypass from the not-yet-committed MEM/WB entry. Also keeps a saturating count of committed writes.

## Interface
- NREGS, 16, register-file depth; the index width is fixed at 4 bits.
- DW, 16, data width; matches the memory-stage writedata width.
- clkwire  in  1  pipeline clock, rising-edge active.
- resetn  in  1  reset, asynchronous, active-low.
- checkwritedata  in  1  memory stage requests a register write this cycle.
- regnum  in  4  destination register index.
- writedata  in  16  data to write.
- stall  in  1  freezes the MEM/WB register and blocks commit.
- readreg1, readreg2  in  4  decode-stage read indices.
- readdata1, readdata2  out  16  read data; combinational.
- wbvalid  out  1  MEM/WB entry is valid (a commit is pending).
- wbreg  out  4  MEM/WB destination index.
- wbdata  out  16  MEM/WB data.
- retired  out  16  count of committed writes; saturates at 16'hFFFF.

## Operation
- **MEM/WB register.** When stall = 0, each rising edge loads wbvalid <= checkwritedata, wbreg <= regnum, wbdata <= writedata. When stall = 1, all three hold.
- **Commit.** On a rising edge with wbvalid = 1, stall = 0 and wbreg != 0:
  - regfile[wbreg] <= wbdata;
  - retired increments (it holds at FFFF once saturated).
- **Register 0.** Hardwired to 0. Writes to it are discarded and do not count toward retired.
- **Read ports.** readdataN = 0 if readregN = 0; otherwise the bypass value (see Configuration); otherwise regfile[readregN].
- **Back-to-back writes.** Two consecutive writes to the same register commit in order; the second one wins.
- **Stall release.** An entry held under stall commits exactly once, on the first edge with stall = 0. On that same edge the next input is loaded.
- **Reset.** resetn low, including mid-stall, asynchronously clears:
  - wbvalid, wbreg, wbdata and retired to 0;
  - all register-file entries to 0.
  
  A pending commit is lost. Leaving reset is synchronous to the next edge.

## Timing
- Input sampled at edge N; the entry is visible on wb* after edge N.
- The register file is updated at edge N+1. Without bypass, a read returns the new value after edge N+1.
- With bypass, a read returns the new value after edge N (one cycle earlier).
- Read ports are combinational, with zero cycles of latency from readregN.
- retired updates on the same edge as the commit.
- Each extra cycle of stall adds one cycle to the commit latency.

## Configuration
- **WB_BYPASS_EN defined:**
  - if wbvalid = 1, wbreg = readregN and readregN != 0, then readdataN = wbdata;
  - the bypass is active regardless of stall.
- **WB_BYPASS_EN undefined:**
  - the read ports see the register file only;
  - decode must tolerate the one-cycle write-to-read gap.
- All other behaviour is identical in both builds.

## Test plan
- **Reset values.** Assert resetn = 0 mid-run. Required: wbvalid = 0, retired = 0, readdata1 = 0 for every readreg1.
- **Single write.** Drive checkwritedata = 1, regnum = 6, writedata = 0x0005 at edge 1, then checkwritedata = 0. Required: wbreg = 6 and wbdata = 0x0005 after edge 1; regfile[6] = 0x0005 and retired = 1 after edge 2.
- **Bypass.** readreg1 = 6 right after edge 1, in the same sequence as the single-write case. Required:
  - with WB_BYPASS_EN: readdata1 = 0x0005;
  - without it: readdata1 = 0, then 0x0005 after edge 2.
- **Register 0.** Write 0xBEEF to reg 0. Required: readdata2 = 0 with readreg2 = 0; retired is unchanged.
- **Stall.** Load reg 9 = 0x000B, then hold stall = 1 for 3 edges. Required: regfile[9] stays unchanged and retired stays unchanged. Then drop stall, with checkwritedata = 1, regnum = 3, writedata = 0x0007 applied. Required: on that edge regfile[9] = 0x000B and retired increments by exactly 1; on the next edge regfile[3] = 0x0007.
- **Saturation and back-to-back writes.**
  - Force 65536 commits. Required: retired = FFFF and stays there.
  - Write reg 4 = 0x1111, then 0x2222 on consecutive cycles. Required: final value 0x2222.
